// File: rtl/demux6_dist.sv
// Registered 1-to-N byte distributor: each accepted beat is steered by sel into a
// per-channel one-entry holding register with valid/ready handshaking.
module demux6_dist #(
    parameter int WIDTH = 8,
    parameter int N_SAL = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       entrada,
    input  logic [2:0]             sel,
    input  logic                   ent_valid,
    output logic                   ent_ready,
    output logic [N_SAL*WIDTH-1:0] salida,
    output logic [N_SAL-1:0]       sal_valid,
    input  logic [N_SAL-1:0]       sal_ready,
    output logic                   err,
    output logic [7:0]             drop_cnt
);

    logic [N_SAL-1:0] full_reg;
    logic [WIDTH-1:0] data_reg [N_SAL];
    logic             err_reg;
    logic [7:0]       drop_cnt_reg;

    logic             out_of_range;
    logic             ready_sel;
    logic             accept;
    logic             drop;

    assign out_of_range = (sel >= 3'(N_SAL));

    // Out-of-range beats are always taken so they can be discarded without stalling.
    always_comb begin
        ready_sel = 1'b1;
        for (int k = 0; k < N_SAL; k++) begin
            if (sel == 3'(k)) begin
                ready_sel = ~full_reg[k] | sal_ready[k];
            end
        end
    end

    assign ent_ready = ready_sel;
    assign accept    = ent_valid & ready_sel;
    assign drop      = accept & out_of_range;

    generate
        for (genvar gi = 0; gi < N_SAL; gi++) begin : g_chan
            logic enq;
            logic deq;

            assign enq = accept & (sel == 3'(gi));
            assign deq = full_reg[gi] & sal_ready[gi];

            // Enqueue wins over dequeue so a ready consumer sees one byte per cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    full_reg[gi] <= 1'b0;
                    data_reg[gi] <= '0;
                end else if (enq) begin
                    full_reg[gi] <= 1'b1;
                    data_reg[gi] <= entrada;
                end else if (deq) begin
                    full_reg[gi] <= 1'b0;
                end
            end

            assign salida[gi*WIDTH +: WIDTH] = data_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg      <= 1'b0;
            drop_cnt_reg <= 8'd0;
        end else begin
            err_reg <= drop;
            if (drop && drop_cnt_reg != 8'hFF) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    assign sal_valid = full_reg;
    assign err       = err_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_demux6_dist.sv
// Directed and randomized checks of demux6_dist against a channel-occupancy model.
module tb_demux6_dist;

    localparam int W = 8;
    localparam int N = 6;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   entrada;
    logic [2:0]     sel;
    logic           ent_valid;
    logic           ent_ready;
    logic [N*W-1:0] salida;
    logic [N-1:0]   sal_valid;
    logic [N-1:0]   sal_ready;
    logic           err;
    logic [7:0]     drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: byte count held per channel, last byte written, drop tally.
    int           mcnt [N];
    logic [W-1:0] mlast [N];
    logic         merr;
    int           mdrop;

    demux6_dist #(.WIDTH(W), .N_SAL(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .entrada   (entrada),
        .sel       (sel),
        .ent_valid (ent_valid),
        .ent_ready (ent_ready),
        .salida    (salida),
        .sal_valid (sal_valid),
        .sal_ready (sal_ready),
        .err       (err),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mcnt[k]  = 0;
            mlast[k] = '0;
        end
        merr  = 1'b0;
        mdrop = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0]   ev;
        logic [N*W-1:0] ed;
        for (int k = 0; k < N; k++) begin
            ev[k]          = (mcnt[k] != 0);
            ed[k*W +: W]   = mlast[k];
        end
        check({tag, "_sal_valid"}, 64'(sal_valid), 64'(ev));
        check({tag, "_salida"},    64'(salida),    64'(ed));
        check({tag, "_err"},       64'(err),       64'(merr));
        check({tag, "_drop_cnt"},  64'(drop_cnt),  64'(mdrop));
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after.
    task automatic cycle(input string tag);
        int   s;
        logic exp_ready;
        logic acc;
        @(negedge clk);
        s = int'(sel);
        exp_ready = (s >= N) ? 1'b1 : ((mcnt[s] == 0) || sal_ready[s]);
        check({tag, "_ent_ready"}, 64'(ent_ready), 64'(exp_ready));
        acc = ent_valid && exp_ready;
        @(posedge clk);
        merr = acc && (s >= N);
        if (merr) mdrop = (mdrop < 255) ? mdrop + 1 : 255;
        for (int k = 0; k < N; k++) begin
            if (mcnt[k] != 0 && sal_ready[k]) mcnt[k] = 0;
            if (acc && s == k) begin
                mcnt[k]  = 1;
                mlast[k] = entrada;
            end
        end
        if (acc && s < N) $display("%s: beat sel=%0d data=%h routed", tag, s, entrada);
        else if (acc)     $display("%s: beat sel=%0d data=%h dropped", tag, s, entrada);
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [W-1:0] d,
                         input logic [N-1:0] r);
        ent_valid = v;
        sel       = s;
        entrada   = d;
        sal_ready = r;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 8'h00, '0);
        model_reset();

        // 1: reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs("t1_reset");
        rst_n = 1'b1;
        cycle("t1_idle");

        // 2: route and hold with consumer stalled
        drive(1'b1, 3'd0, 8'hE1, '0);
        cycle("t2_beat");
        check("t2_valid_vec", 64'(sal_valid), 64'h01);
        check("t2_data",      64'(salida[7:0]), 64'hE1);
        drive(1'b0, 3'd0, 8'h00, '0);
        for (int i = 0; i < 5; i++) cycle("t2_hold");
        check("t2_data_held", 64'(salida[7:0]), 64'hE1);

        // 3: backpressure, then same-cycle release
        drive(1'b1, 3'd2, 8'hE3, '0);
        cycle("t3_fill");
        drive(1'b1, 3'd2, 8'hEC, '0);
        cycle("t3_blocked");
        check("t3_blocked_data", 64'(salida[23:16]), 64'hE3);
        drive(1'b1, 3'd2, 8'hEC, 6'b000100);
        cycle("t3_release");
        check("t3_new_data", 64'(salida[23:16]), 64'hEC);
        check("t3_valid2",   64'(sal_valid[2]), 64'h1);

        // 4: out-of-range drops and saturation
        drive(1'b0, 3'd0, 8'h00, 6'h3F);
        cycle("t4_drain");
        drive(1'b1, 3'd6, 8'hA6, '0);
        cycle("t4_sel6");
        check("t4_err1", 64'(err), 64'h1);
        drive(1'b1, 3'd7, 8'hA7, '0);
        cycle("t4_sel7");
        check("t4_err2", 64'(err), 64'h1);
        check("t4_cnt2", 64'(drop_cnt), 64'd2);
        drive(1'b0, 3'd0, 8'h00, '0);
        cycle("t4_err_off");
        check("t4_err_off", 64'(err), 64'h0);
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 3'(6 + (i % 2)), 8'(i), '0);
            cycle("t4_flood");
        end
        check("t4_saturated", 64'(drop_cnt), 64'd255);

        // 5: streaming with all consumers ready
        for (int k = 0; k < N; k++) begin
            drive(1'b1, 3'(k), 8'(8'hE1 + k), 6'h3F);
            cycle("t5_stream");
            check("t5_onehot", 64'(sal_valid), 64'(1 << k));
            check("t5_data", 64'(salida[k*W +: W]), 64'(8'hE1 + k));
        end
        drive(1'b0, 3'd0, 8'h00, 6'h3F);
        cycle("t5_tail");
        check("t5_empty", 64'(sal_valid), 64'h0);

        // 6: asynchronous reset between clock edges
        drive(1'b1, 3'd1, 8'h51, '0);
        cycle("t6_fill1");
        drive(1'b1, 3'd4, 8'h54, '0);
        cycle("t6_fill4");
        drive(1'b0, 3'd0, 8'h00, '0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_async_valid", 64'(sal_valid), 64'h0);
        check("t6_async_salida", 64'(salida), 64'h0);
        #1;
        rst_n = 1'b1;
        cycle("t6_after");
        cycle("t6_after2");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  8'($urandom), 6'($urandom));
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
